// File: rtl/sid_voice_mixer_if.sv
// Bus bundle between the voice generators, the filter and the mixer: voice/register inputs, mixed outputs.
// The master modport drives ce_1m, the voices and the register images; the slave modport (the mixer) returns samples and status.
interface sid_voice_mixer_if;
  logic               ce_1m;
  logic signed [11:0] voice1;
  logic signed [11:0] voice2;
  logic signed [11:0] voice3;
  logic signed [15:0] filt_in;
  logic        [7:0]  res_filt;
  logic        [7:0]  mode_vol;
  logic signed [15:0] filt_out;
  logic signed [15:0] audio_out;
  logic               audio_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output ce_1m, voice1, voice2, voice3, filt_in, res_filt, mode_vol,
    input  filt_out, audio_out, audio_valid, busy, overrun
  );

  modport slave (
    input  ce_1m, voice1, voice2, voice3, filt_in, res_filt, mode_vol,
    output filt_out, audio_out, audio_valid, busy, overrun
  );
endinterface

// File: rtl/sid_voice_mixer.sv
// SID voice router/mixer: filter send, 3OFF, volume scale, saturation; SID_MIX_DIGI_EN adds a +512 DC offset.
// Latency 6 clocks from ce_1m; no backpressure -- ce_1m while busy is dropped and sets sticky overrun.
module sid_voice_mixer (
  input  logic           clock,
  input  logic           reset,
  sid_voice_mixer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACC1, ACC2, ACC3, MIX, SCALE, OUT} state_t;

`ifdef SID_MIX_DIGI_EN
  localparam logic [16:0] DC_OFFSET = 17'd512;
`else
  localparam logic [16:0] DC_OFFSET = 17'd0;
`endif

  state_t             state;
  logic signed [11:0] v1_s, v2_s, v3_s;
  logic signed [15:0] fin_s;
  logic        [2:0]  route_s;
  logic               off3_s;
  logic        [3:0]  vol_s;
  logic signed [15:0] facc;
  logic signed [13:0] dacc;
  logic signed [16:0] mix;
  logic signed [21:0] prod;
  logic signed [21:0] scaled;
  logic               unused_bits;

  assign scaled      = prod >>> 4;
  assign unused_bits = &{1'b0, bus.res_filt[7:3], bus.mode_vol[6:4]};

  function automatic logic signed [15:0] sx16(input logic signed [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  function automatic logic signed [13:0] sx14(input logic signed [11:0] v);
    return {{2{v[11]}}, v};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      v1_s            <= '0;
      v2_s            <= '0;
      v3_s            <= '0;
      fin_s           <= '0;
      route_s         <= '0;
      off3_s          <= 1'b0;
      vol_s           <= '0;
      facc            <= '0;
      dacc            <= '0;
      mix             <= '0;
      prod            <= '0;
      bus.filt_out    <= '0;
      bus.audio_out   <= '0;
      bus.audio_valid <= 1'b0;
      bus.busy        <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.audio_valid <= 1'b0;
      if (bus.ce_1m && state != IDLE) bus.overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.ce_1m) begin
            v1_s     <= bus.voice1;
            v2_s     <= bus.voice2;
            v3_s     <= bus.voice3;
            fin_s    <= bus.filt_in;
            route_s  <= bus.res_filt[2:0];
            off3_s   <= bus.mode_vol[7];
            vol_s    <= bus.mode_vol[3:0];
            facc     <= '0;
            dacc     <= '0;
            bus.busy <= 1'b1;
            state    <= ACC1;
          end
        end
        ACC1: begin
          if (route_s[0]) facc <= facc + sx16(v1_s);
          else            dacc <= dacc + sx14(v1_s);
          state <= ACC2;
        end
        ACC2: begin
          if (route_s[1]) facc <= facc + sx16(v2_s);
          else            dacc <= dacc + sx14(v2_s);
          state <= ACC3;
        end
        ACC3: begin
          // 3OFF only mutes voice 3 on the direct path; a routed voice 3 still feeds the filter.
          if (route_s[2])   facc <= facc + sx16(v3_s);
          else if (!off3_s) dacc <= dacc + sx14(v3_s);
          state <= MIX;
        end
        MIX: begin
          bus.filt_out <= facc;
          mix   <= {{3{dacc[13]}}, dacc} + {fin_s[15], fin_s} + DC_OFFSET;
          state <= SCALE;
        end
        SCALE: begin
          prod  <= 22'(mix) * 22'($signed({1'b0, vol_s}));
          state <= OUT;
        end
        OUT: begin
          if (scaled > 22'sd32767)       bus.audio_out <= 16'sh7fff;
          else if (scaled < -22'sd32768) bus.audio_out <= 16'sh8000;
          else                           bus.audio_out <= scaled[15:0];
          bus.audio_valid <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_voice_mixer.sv
// Self-checking bench for sid_voice_mixer: directed test-plan cases plus randomized traffic against a behavioural model.
module tb_sid_voice_mixer;
  logic clock = 1'b0;
  logic reset = 1'b1;

  sid_voice_mixer_if bus();

  sid_voice_mixer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

`ifdef SID_MIX_DIGI_EN
  localparam int DC        = 512;
  localparam int DIGI_EXP  = 480;
  localparam int BASIC_EXP = 2399;
  localparam int MIXED_EXP = 606;
  localparam int FLOOR_EXP = 31;
`else
  localparam int DC        = 0;
  localparam int DIGI_EXP  = 0;
  localparam int BASIC_EXP = 1919;
  localparam int MIXED_EXP = 350;
  localparam int FLOOR_EXP = -1;
`endif

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one pass computed directly from the mixing rules with plain integers.
  function automatic void ref_pass(input int v1, input int v2, input int v3, input int fi,
                                   input logic [7:0] rf, input logic [7:0] mv,
                                   output int audio, output int filt);
    int f;
    int d;
    int m;
    int s;
    f = 0;
    d = 0;
    if (rf[0]) f += v1; else d += v1;
    if (rf[1]) f += v2; else d += v2;
    if (rf[2]) f += v3; else if (!mv[7]) d += v3;
    m = d + fi + DC;
    s = (m * int'(mv[3:0])) >>> 4;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    audio = s;
    filt  = f;
  endfunction

  // Cycle-level expectations: a pass started at edge T publishes filt at T+4 and audio/valid at T+6.
  int cyc = 0;
  int start = 0;
  bit mbusy = 1'b0;
  int a_next = 0;
  int f_next = 0;
  int e_audio = 0;
  int e_filt = 0;
  bit e_valid = 1'b0;
  bit e_busy = 1'b0;
  bit e_ovr = 1'b0;
  bit chk_en = 1'b0;

  always @(posedge clock) begin : model
    bit was_busy;
    was_busy = mbusy;
    cyc++;
    if (reset) begin
      mbusy   = 1'b0;
      e_audio = 0;
      e_filt  = 0;
      e_valid = 1'b0;
      e_ovr   = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (mbusy && cyc == start + 4) e_filt = f_next;
      if (mbusy && cyc == start + 6) begin
        e_audio = a_next;
        e_valid = 1'b1;
        mbusy   = 1'b0;
      end
      if (bus.ce_1m) begin
        if (was_busy) e_ovr = 1'b1;
        else begin
          start = cyc;
          mbusy = 1'b1;
          ref_pass(int'(bus.voice1), int'(bus.voice2), int'(bus.voice3), int'(bus.filt_in),
                   bus.res_filt, bus.mode_vol, a_next, f_next);
        end
      end
    end
    e_busy = mbusy;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("audio_out",   int'(bus.audio_out), e_audio);
      chk("filt_out",    int'(bus.filt_out),  e_filt);
      chk("audio_valid", int'(bus.audio_valid), int'(e_valid));
      chk("busy",        int'(bus.busy),      int'(e_busy));
      chk("overrun",     int'(bus.overrun),   int'(e_ovr));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int v1, input int v2, input int v3, input int fi,
                        input logic [7:0] rf, input logic [7:0] mv);
    bus.voice1   = 12'(v1);
    bus.voice2   = 12'(v2);
    bus.voice3   = 12'(v3);
    bus.filt_in  = 16'(fi);
    bus.res_filt = rf;
    bus.mode_vol = mv;
  endtask

  // Returns on the negedge where audio_valid is seen; lat counts edges after the ce_1m edge.
  task automatic wait_valid(input string nm, input int exp_a, input int exp_f, input int exp_lat);
    int lat;
    lat = -1;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clock);
      if (bus.audio_valid) begin
        lat = n;
        break;
      end
    end
    chk({nm, "_latency"}, lat, exp_lat);
    if (lat >= 0) begin
      chk({nm, "_audio"}, int'(bus.audio_out), exp_a);
      chk({nm, "_filt"},  int'(bus.filt_out),  exp_f);
    end
  endtask

  task automatic pulse();
    bus.ce_1m = 1'b1;
    tick();
    bus.ce_1m = 1'b0;
  endtask

  task automatic count_valid(input string nm, input int ncyc, input int exp);
    int cnt;
    cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clock);
      if (bus.audio_valid) cnt++;
    end
    chk(nm, cnt, exp);
  endtask

  initial begin
    int a;
    int f;
    bus.ce_1m = 1'b0;
    set_in(0, 0, 0, 0, 8'h00, 8'h00);
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_audio", int'(bus.audio_out), 0);
    chk("rst_filt",  int'(bus.filt_out), 0);
    chk("rst_valid", int'(bus.audio_valid), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_ovr",   int'(bus.overrun), 0);

    ref_pass(2047, 0, 0, 0, 8'h00, 8'h0F, a, f);
    chk("model_basic", a, BASIC_EXP);
    ref_pass(0, 0, 0, 0, 8'h00, 8'h0F, a, f);
    chk("model_digi", a, DIGI_EXP);
    ref_pass(0, -1, 0, 0, 8'h00, 8'h01, a, f);
    chk("model_floor", a, FLOOR_EXP);

    set_in(2047, 0, 0, 0, 8'h00, 8'h0F);      pulse(); wait_valid("basic", BASIC_EXP, 0, 6);
    set_in(0, 0, 1000, 0, 8'h00, 8'h8F);      pulse(); wait_valid("off3", DIGI_EXP, 0, 6);
    set_in(0, 0, 1000, 0, 8'h04, 8'h8F);      pulse(); wait_valid("off3_routed", DIGI_EXP, 1000, 6);
    set_in(2047, 2047, 2047, 32767, 8'h00, 8'h0F);     pulse(); wait_valid("sat_pos", 32767, 0, 6);
    set_in(-2048, -2048, -2048, -32768, 8'h00, 8'h0F); pulse(); wait_valid("sat_neg", -32768, 0, 6);
    set_in(100, -300, 50, 1000, 8'h05, 8'h08); pulse(); wait_valid("mixed", MIXED_EXP, 150, 6);
    set_in(0, -1, 0, 0, 8'h00, 8'h01);         pulse(); wait_valid("floor", FLOOR_EXP, 0, 6);
    set_in(0, 0, 0, 0, 8'h00, 8'h0F);          pulse(); wait_valid("digi_vol15", DIGI_EXP, 0, 6);
    set_in(0, 0, 0, 0, 8'h00, 8'h00);          pulse(); wait_valid("digi_vol0", 0, 0, 6);

    // Second ce_1m three edges into a pass, with every input changed.
    set_in(2047, 0, 0, 0, 8'h00, 8'h0F);
    pulse();
    tick();
    tick();
    set_in(-2048, -2048, -2048, -5000, 8'h07, 8'h8F);
    pulse();
    wait_valid("overrun_pass", BASIC_EXP, 0, 3);
    chk("overrun_flag", int'(bus.overrun), 1);
    count_valid("overrun_single", 10, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("overrun_cleared", int'(bus.overrun), 0);

    // Reset two edges into a pass aborts it silently.
    set_in(2047, 0, 0, 0, 8'h01, 8'h0F);
    pulse();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("abort_busy",  int'(bus.busy), 0);
    chk("abort_audio", int'(bus.audio_out), 0);
    chk("abort_filt",  int'(bus.filt_out), 0);
    count_valid("abort_novalid", 10, 0);
    set_in(2047, 0, 0, 0, 8'h00, 8'h0F); pulse(); wait_valid("after_abort", BASIC_EXP, 0, 6);

    for (int i = 0; i < 3000; i++) begin
      bus.voice1   = ($urandom_range(0, 3) == 0) ? 12'h7ff : 12'($urandom);
      bus.voice2   = ($urandom_range(0, 3) == 0) ? 12'h800 : 12'($urandom);
      bus.voice3   = 12'($urandom);
      bus.filt_in  = ($urandom_range(0, 3) == 0) ? 16'h7fff : 16'($urandom);
      bus.res_filt = 8'($urandom);
      bus.mode_vol = 8'($urandom);
      bus.ce_1m    = ($urandom_range(0, 5) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      tick();
    end
    bus.ce_1m = 1'b0;
    reset     = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sid_voice_mixer.md
# sid_voice_mixer

Downstream stage of the three per-voice generators in one SID instance. It routes each voice's signed 12-bit `signal_out` either to the filter send bus or to the direct path. It applies the 3OFF rule, sums the direct path with the filter return, and scales by the 4-bit master volume. A short multi-cycle state machine runs once per `ce_1m` and produces one saturated signed 16-bit sample with a valid strobe for the audio output path.

## Interface
Parameters: none.
- clock  in  1  system clock; must be at least 7x the `ce_1m` rate
- reset  in  1  synchronous, active-high
- ce_1m  in  1  1 MHz sample enable; starts one mixing pass
- voice1  in  12  signed voice 1 output
- voice2  in  12  signed voice 2 output
- voice3  in  12  signed voice 3 output
- filt_in  in  16  signed filter return sample
- res_filt  in  8  $D417 image; bits [2:0] route voice 1..3 to filter
- mode_vol  in  8  $D418 image; [7] = 3OFF, [3:0] = volume
- filt_out  out  16  signed filter send: sum of routed voices
- audio_out  out  16  signed mixed, scaled, saturated sample
- audio_valid  out  1  one-cycle strobe when `audio_out` updates
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky; set when `ce_1m` arrives while busy

## Operation
- States: IDLE, ACC1, ACC2, ACC3, MIX, SCALE, OUT.
- IDLE with `ce_1m`:
  - Capture all of voice1..3, filt_in, res_filt[2:0], mode_vol[7] and mode_vol[3:0] into shadow registers.
  - Clear `facc` (16-bit signed) and `dacc` (14-bit signed).
  - Go to ACC1.
- ACCn (n = 1..3):
  - The sign-extended voice n is added to `facc` if routed bit n-1 = 1, otherwise to `dacc`.
  - Exception: voice 3 unrouted with 3OFF = 1 is added to neither. 3OFF never affects a routed voice 3.
- MIX:
  - `filt_out <= facc`.
  - `mix` (17-bit signed) = sext(`dacc`) + sext(filt_in) [+ 512, see Configuration].
- SCALE:
  - `prod` (22-bit signed) = `mix` * {1'b0, vol}.
  - `s` = `prod` >>> 4 (arithmetic shift).
- OUT:
  - `audio_out` = clamp(`s`, -32768, 32767).
  - `audio_valid` = 1 for exactly this cycle.
  - Return to IDLE.
- Only one multiplier; all adds are done at the width stated, with no internal overflow possible.
- `ce_1m` seen in any state other than IDLE: ignored, `overrun` <= 1, and the current pass completes unchanged.
- Input changes after capture have no effect on the current pass.
- Reset values (including reset asserted mid-pass):
  - state = IDLE; all of filt_out, audio_out, audio_valid, busy, overrun = 0.
  - Shadow registers and accumulators = 0.
  - No `audio_valid` is produced for an aborted pass.
- `overrun` clears only on reset.

## Timing
- `ce_1m` sampled at edge T (IDLE) → state ACC1 at T+1.
- `filt_out` updates at edge T+4.
- `audio_out` and `audio_valid` are registered at edge T+6; latency 6 clocks.
- `busy` is high from T+1 through the OUT cycle.
- A new pass may start on the cycle after OUT, so minimum `ce_1m` spacing is 7 clocks.
- `ce_1m` together with reset: reset wins, and no capture occurs.
- `audio_out` and `filt_out` hold their values between updates.

## Configuration
- `SID_MIX_DIGI_EN` defined: a constant DC offset of +512 is added to `mix` in MIX, so volume writes alone produce an audible step (legacy 4-bit digi playback).
  - Example: silent voices, vol 15 → `audio_out` = 480.
- Undefined: no offset is added; silent voices produce 0 at any volume.
- Ports and timing are identical in both builds.

## Test plan
- Basic mix: voice1=2047, voice2=voice3=0, filt_in=0, res_filt=0x00, mode_vol=0x0F, pulse `ce_1m` → `audio_valid` at T+6 with `audio_out`=1919, and `filt_out`=0.
- 3OFF:
  - voice3=1000, others 0, mode_vol=0x8F, res_filt=0x00 → `audio_out`=0.
  - Repeat with res_filt=0x04 → `filt_out`=1000 at T+4 and `audio_out`=0 (filt_in=0).
- Saturation:
  - filt_in=32767, all voices=2047, res_filt=0, vol 15 → `audio_out`=32767.
  - filt_in=-32768, all voices=-2048 → `audio_out`=-32768.
- Overrun: `ce_1m` at T and at T+3 → exactly one `audio_valid` (at T+6), `overrun`=1, and the value is unaffected by inputs changed at T+3.
- Reset mid-pass: `ce_1m` at T, reset at T+2 → no `audio_valid`; `audio_out`, `filt_out`, `busy` = 0; the next `ce_1m` completes normally.
- Digi: all inputs 0, mode_vol=0x0F → `audio_out`=480 with `SID_MIX_DIGI_EN`, 0 without; with mode_vol=0x00 → 0 in both builds.
